// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between an instruction-fetch port and a load/store port.
// Data normally wins; a saturating streak counter bounds how long a fetch can starve.
module mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_D  = 2'd2
    } state_t;

    localparam logic [3:0] MaxStreak = 4'(MAX_DATA_STREAK);

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_streak;
    logic        w_ifGnt;
    logic        w_dGnt;

    // Grants are gated by rst so every output reads zero while reset is held.
    always_comb begin
        w_ifGnt = 1'b0;
        w_dGnt  = 1'b0;
        if (rst) begin
            if (d_req && (!if_req || (r_streak != MaxStreak))) begin
                w_dGnt = 1'b1;
            end else if (if_req) begin
                w_ifGnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_ifGnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (w_dGnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    assign if_gnt    = w_ifGnt;
    assign d_gnt     = w_dGnt;
    assign cpu_stall = rst & ((if_req & ~w_ifGnt) | (d_req & ~w_dGnt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_streak <= 4'd0;
        end else if (w_ifGnt) begin
            r_streak <= 4'd0;
        end else if (w_dGnt && if_req && (r_streak != MaxStreak)) begin
            r_streak <= r_streak + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state depends only on this cycle's grant, so reads can be pipelined back to back.
    always_comb begin
        w_nextState = IDLE;
        if_rvalid   = 1'b0;
        if_rdata    = '0;
        d_rvalid    = 1'b0;
        d_rdata     = '0;
        if (w_ifGnt) begin
            w_nextState = RD_IF;
        end else if (w_dGnt && !d_we) begin
            w_nextState = RD_D;
        end
        case (r_state)
            RD_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
            RD_D: begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized traffic,
// checked every cycle against a behavioural model of the arbitration rules.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          cpu_stall;

    int compared   = 0;
    int mismatched = 0;
    int mStreak    = 0;
    int mPend      = 0;
    bit ifHold     = 1'b0;
    bit dHold      = 1'b0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are set at a falling edge; outputs are checked 1ns later, then the model advances.
    task automatic applyStimulus(input string tag);
        bit            eIf;
        bit            eD;
        bit            eRdIf;
        bit            eRdD;
        bit            eWe;
        logic [AW-1:0] eAddr;
        logic [DW-1:0] eWd;
        #1;
        eIf = 1'b0; eD = 1'b0; eRdIf = 1'b0; eRdD = 1'b0;
        eWe = 1'b0; eAddr = '0; eWd = '0;
        if (rst) begin
            eD    = d_req && (!if_req || (mStreak != MAXS));
            eIf   = if_req && !eD;
            eRdIf = (mPend == 1);
            eRdD  = (mPend == 2);
        end
        if (eIf) begin
            eAddr = if_addr;
        end else if (eD) begin
            eAddr = d_addr;
            eWe   = d_we;
            eWd   = d_wdata;
        end
        checkOutput({tag, ".if_gnt"},    64'(if_gnt),    64'(eIf));
        checkOutput({tag, ".d_gnt"},     64'(d_gnt),     64'(eD));
        checkOutput({tag, ".mem_en"},    64'(mem_en),    64'(eIf || eD));
        checkOutput({tag, ".mem_we"},    64'(mem_we),    64'(eWe));
        checkOutput({tag, ".mem_addr"},  64'(mem_addr),  64'(eAddr));
        checkOutput({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(eWd));
        checkOutput({tag, ".cpu_stall"}, 64'(cpu_stall),
                    64'(rst && ((if_req && !eIf) || (d_req && !eD))));
        checkOutput({tag, ".if_rvalid"}, 64'(if_rvalid), 64'(eRdIf));
        checkOutput({tag, ".if_rdata"},  64'(if_rdata),  eRdIf ? 64'(mem_rdata) : 64'd0);
        checkOutput({tag, ".d_rvalid"},  64'(d_rvalid),  64'(eRdD));
        checkOutput({tag, ".d_rdata"},   64'(d_rdata),   eRdD ? 64'(mem_rdata) : 64'd0);
        if (!rst) begin
            mPend   = 0;
            mStreak = 0;
        end else begin
            mPend = eIf ? 1 : ((eD && !d_we) ? 2 : 0);
            if (eIf) mStreak = 0;
            else if (eD && if_req && mStreak < MAXS) mStreak++;
        end
        ifHold = if_req && !eIf;
        dHold  = d_req && !eD;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0;
        d_addr = 32'h200; d_wdata = 32'h33; mem_rdata = 32'h1234;
        @(negedge clk);
        applyStimulus("reset");
        applyStimulus("reset2");
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        applyStimulus("idle");

        if_req = 1'b1; if_addr = 32'h10;
        applyStimulus("fetch");
        if_req = 1'b0; mem_rdata = 32'hDEADBEEF;
        applyStimulus("fetchRd");

        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h5; mem_rdata = 32'h0;
        applyStimulus("store");
        d_req = 1'b0; mem_rdata = 32'hCAFE0001;
        applyStimulus("storeAfter");

        // Continuous contention: the grant pattern must be D,D,D,D,F repeating.
        if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
        for (int i = 0; i < 10; i++) begin
            mem_rdata = $urandom;
            #1;
            checkOutput("seq.if_gnt", 64'(if_gnt), 64'((i == 4) || (i == 9)));
            checkOutput("seq.d_gnt", 64'(d_gnt), 64'((i != 4) && (i != 9)));
            checkOutput("seq.stall", 64'(cpu_stall), 64'd1);
            #1;
            applyStimulus("both");
        end
        if_req = 1'b0;
        applyStimulus("drain");
        d_req = 1'b0;
        applyStimulus("drainIdle");

        if_req = 1'b1; if_addr = 32'h300; mem_rdata = 32'h0;
        applyStimulus("b2bFetch");
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; mem_rdata = 32'hAAAA5555;
        applyStimulus("b2bLoad");
        d_req = 1'b0; mem_rdata = 32'h5555AAAA;
        applyStimulus("b2bLoadRd");

        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; mem_rdata = 32'h0;
        applyStimulus("preRstLoad");
        d_req = 1'b0; rst = 1'b0; mem_rdata = 32'h77777777;
        applyStimulus("midRst");
        applyStimulus("midRst2");
        rst = 1'b1;
        applyStimulus("postRst");
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("postRstSeq.if_gnt", 64'(if_gnt), 64'(i == 4));
            #1;
            applyStimulus("postRstBoth");
        end

        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 49) != 0);
            if (!ifHold) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = $urandom;
            end
            if (!dHold) begin
                d_req   = ($urandom_range(0, 3) != 0);
                d_we    = $urandom_range(0, 1);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            mem_rdata = $urandom;
            applyStimulus("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: width of every address bus.
REQ-002 Parameter DATA_W, default 32: width of every data bus.
REQ-003 Parameter MAX_DATA_STREAK, default 4, range 1..15: maximum number of consecutive data grants while a fetch request waits.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 if_req  in  1  instruction-fetch read request.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_gnt  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid  out  1  fetch read data valid.
REQ-010 if_rdata  out  DATA_W  fetch read data.
REQ-011 d_req  in  1  load/store request.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  ADDR_W  data address.
REQ-014 d_wdata  in  DATA_W  store data.
REQ-015 d_gnt  out  1  data request accepted this cycle.
REQ-016 d_rvalid  out  1  load data valid.
REQ-017 d_rdata  out  DATA_W  load data.
REQ-018 mem_en  out  1  memory access strobe.
REQ-019 mem_we  out  1  memory write enable.
REQ-020 mem_addr  out  ADDR_W  memory address.
REQ-021 mem_wdata  out  DATA_W  memory write data.
REQ-022 mem_rdata  in  DATA_W  memory read data, valid exactly one cycle after a read strobe.
REQ-023 cpu_stall  out  1  high when any request is pending but not granted this cycle.

Function
REQ-024 Arbitration SHALL be combinational: at most one of if_gnt and d_gnt is high per cycle, and a grant is issued whenever at least one request is high.
REQ-025 A request SHALL stay asserted, with stable address and data, until its grant; a grant completes the request in that same cycle.
REQ-026 On a grant, mem_en SHALL be 1 and mem_addr, mem_we and mem_wdata SHALL carry the granted requester's fields; for a fetch, mem_we = 0 and mem_wdata = 0.
REQ-027 With no grant, mem_en = 0, mem_we = 0, and mem_addr = mem_wdata = 0.
REQ-028 With only one requester, that requester SHALL be granted.
REQ-029 With both requesting, data SHALL win unless streak == MAX_DATA_STREAK, in which case fetch SHALL win.
REQ-030 A 4-bit streak counter SHALL increment on a data grant while if_req is high, clear on a fetch grant, and otherwise hold.
REQ-031 The streak counter SHALL saturate at MAX_DATA_STREAK.
REQ-032 A read-tracking FSM SHALL have three states:
- IDLE
- RD_IF
- RD_D
REQ-033 Next FSM state SHALL be RD_IF after a fetch grant, RD_D after a load grant, and IDLE after a store grant or no grant; this holds from any current state, so back-to-back pipelined grants are allowed.
REQ-034 In RD_IF, if_rvalid = 1 and if_rdata = mem_rdata; in RD_D, d_rvalid = 1 and d_rdata = mem_rdata.
REQ-035 Each rdata output SHALL be 0 whenever its rvalid is 0.
REQ-036 Read latency SHALL be exactly one cycle from grant to rvalid; stores SHALL produce no rvalid.
REQ-037 cpu_stall SHALL equal (if_req & ~if_gnt) | (d_req & ~d_gnt).

Reset
REQ-038 While rst = 0, the FSM SHALL be IDLE and streak = 0.
REQ-039 While rst = 0, all grants, rvalids, mem_en, mem_we and cpu_stall SHALL be 0, and all data and address outputs SHALL be 0.
REQ-040 Reset asserted mid-read SHALL discard the pending read: no rvalid after reset is released.
REQ-041 Arbitration SHALL resume on the first rising edge after rst returns to 1.

Verification
REQ-042 Fetch only: if_req = 1, if_addr = 0x10; mem_rdata = 0xDEADBEEF next cycle -> if_gnt in cycle 0, then if_rvalid = 1 and if_rdata = 0xDEADBEEF in cycle 1.
REQ-043 Store only: d_req = 1, d_we = 1, d_addr = 0x40, d_wdata = 0x5 -> mem_en = 1, mem_we = 1, mem_addr = 0x40, mem_wdata = 0x5; no rvalid in the following cycle.
REQ-044 Both requesting continuously with MAX_DATA_STREAK = 4 -> grant sequence D,D,D,D,F,D,D,D,D,F; cpu_stall = 1 every cycle.
REQ-045 Fetch grant in cycle 0, load grant in cycle 1 -> if_rvalid in cycle 1, d_rvalid in cycle 2, each carrying its own mem_rdata.
REQ-046 rst pulled low one cycle after a load grant -> d_rvalid = 0 during reset and after release; streak = 0.
